kbd_midi_bridge: RTL

KBD_MIDI_BRIDGE -- requirements
Module: kbd_midi_bridge

---
 rtl/kbd_midi_pkg.sv | 27 ++
 rtl/kbd_midi_bridge_if.sv | 23 ++
 rtl/kbd_midi_encoder.sv | 37 +++
 rtl/kbd_midi_bridge.sv | 138 +++++++++++++
 4 files changed

// File: rtl/kbd_midi_pkg.sv
// rtl/kbd_midi_pkg.sv - shared types and constants for the keyboard-to-MIDI bridge
package kbd_midi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_STATUS,
    RD_EVENT,
    EMIT_S,
    EMIT_N,
    EMIT_V
  } state_t;

  localparam logic [31:0] STATUS_OFS       = 32'h0000_0004;
  localparam logic [31:0] EVENT_OFS        = 32'h0000_0008;
  localparam int          STATUS_AVAIL_BIT = 1;

  localparam int KEY_LSB   = 0;
  localparam int VEL_LSB   = 8;
  localparam int PRESS_BIT = 16;

  localparam logic [3:0] NOTE_ON_NIBBLE  = 4'h9;
  localparam logic [3:0] NOTE_OFF_NIBBLE = 4'h8;
  localparam logic [7:0] RELEASE_VEL     = 8'h40;
  localparam logic [7:0] NUM_KEYS        = 8'd42;
  localparam logic [3:0] TIMEOUT_LAST    = 4'd15;

endpackage

// File: rtl/kbd_midi_bridge_if.sv
// rtl/kbd_midi_bridge_if.sv - Wishbone scanner bus and MIDI byte stream bundle
interface kbd_midi_bridge_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic [7:0]  midi_data;
  logic        midi_valid;
  logic        midi_ready;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, midi_data, midi_valid,
    input  wbm_dat_i, wbm_ack_i, midi_ready
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, midi_data, midi_valid,
    output wbm_dat_i, wbm_ack_i, midi_ready
  );
endinterface

// File: rtl/kbd_midi_encoder.sv
// rtl/kbd_midi_encoder.sv - maps a scanner event word to three MIDI bytes plus drop flag
module kbd_midi_encoder
  import kbd_midi_pkg::*;
#(
  parameter logic [3:0] MIDI_CHANNEL = 4'h0,
  parameter logic [7:0] NOTE_BASE    = 8'd36
) (
  input  logic [16:0] evt_word,
  output logic [7:0]  status,
  output logic [7:0]  note,
  output logic [7:0]  vel,
  output logic        drop
);
  logic [7:0] key;
  logic [7:0] velocity;
  logic       pressed;
  logic [8:0] note_wide;

  always_comb begin
    key       = evt_word[KEY_LSB +: 8];
    velocity  = evt_word[VEL_LSB +: 8];
    pressed   = evt_word[PRESS_BIT];
    // Nine bits so a large NOTE_BASE + key cannot wrap back into range.
    note_wide = {1'b0, NOTE_BASE} + {1'b0, key};
    drop      = (key >= NUM_KEYS) || (note_wide > 9'd127);
    note      = note_wide[7:0];
    status    = {pressed ? NOTE_ON_NIBBLE : NOTE_OFF_NIBBLE, MIDI_CHANNEL};
    if (!pressed)
      vel = RELEASE_VEL;
    else if (velocity > 8'd127)
      vel = 8'd127;
    else if (velocity == 8'd0)
      vel = 8'd1;
    else
      vel = velocity;
  end
endmodule

// File: rtl/kbd_midi_bridge.sv
// rtl/kbd_midi_bridge.sv - polls the key scanner over Wishbone and emits MIDI note messages
// Optional running status: define KBD_MIDI_RUNNING_STATUS_EN.
module kbd_midi_bridge
  import kbd_midi_pkg::*;
#(
  parameter logic [31:0] SCANNER_BASE = 32'h0000_0000,
  parameter logic [3:0]  MIDI_CHANNEL = 4'h0,
  parameter logic [7:0]  NOTE_BASE    = 8'd36,
  parameter logic [15:0] POLL_DIV     = 16'd1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      irq_in,
  kbd_midi_bridge_if.master         bus,
  output logic                      busy,
  output logic [7:0]                drop_count,
  output logic                      wb_err
);
  state_t      state;
  logic        cyc, stb;
  logic [31:0] adr;
  logic [3:0]  to_cnt;
  logic [15:0] poll_cnt;
  logic [7:0]  data_q, status_q, note_q, vel_q;
  logic        valid_q;
  logic [7:0]  enc_status, enc_note, enc_vel;
  logic        enc_drop, rs_skip, rd_state, timeout;

  kbd_midi_encoder #(.MIDI_CHANNEL(MIDI_CHANNEL), .NOTE_BASE(NOTE_BASE)) u_encoder (
    .evt_word (bus.wbm_dat_i[16:0]),
    .status   (enc_status),
    .note     (enc_note),
    .vel      (enc_vel),
    .drop     (enc_drop)
  );

  assign bus.wbm_cyc_o  = cyc;
  assign bus.wbm_stb_o  = stb;
  assign bus.wbm_we_o   = 1'b0;
  assign bus.wbm_adr_o  = adr;
  assign bus.wbm_dat_o  = 32'h0;
  assign bus.midi_data  = data_q;
  assign bus.midi_valid = valid_q;
  assign busy           = (state != IDLE);
  assign rd_state       = (state == RD_STATUS) || (state == RD_EVENT);
  assign timeout        = rd_state && stb && !bus.wbm_ack_i && (to_cnt == TIMEOUT_LAST);

`ifdef KBD_MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;
  always_ff @(posedge clk) begin
    if (rst || timeout || !enable)
      last_status <= 8'h00;
    else if (state == EMIT_S && bus.midi_ready)
      last_status <= status_q;
  end
  assign rs_skip = (enc_status == last_status);
`else
  assign rs_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cyc        <= 1'b0;
      stb        <= 1'b0;
      adr        <= 32'h0;
      to_cnt     <= 4'h0;
      poll_cnt   <= 16'h0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      status_q   <= 8'h00;
      note_q     <= 8'h00;
      vel_q      <= 8'h00;
      drop_count <= 8'h00;
      wb_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            if (irq_in || poll_cnt == POLL_DIV - 16'd1) begin
              poll_cnt <= 16'h0;
              state    <= RD_STATUS;
            end else begin
              poll_cnt <= poll_cnt + 16'd1;
            end
          end
        end
        RD_STATUS, RD_EVENT: begin
          // Each read state opens its own cycle, so reads never overlap.
          if (!stb) begin
            cyc    <= 1'b1;
            stb    <= 1'b1;
            to_cnt <= 4'h0;
            adr    <= SCANNER_BASE + ((state == RD_STATUS) ? STATUS_OFS : EVENT_OFS);
          end else if (bus.wbm_ack_i) begin
            cyc <= 1'b0;
            stb <= 1'b0;
            if (state == RD_STATUS) begin
              state <= (bus.wbm_dat_i[STATUS_AVAIL_BIT] && enable) ? RD_EVENT : IDLE;
            end else if (enc_drop) begin
              if (drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
              state <= enable ? RD_STATUS : IDLE;
            end else begin
              status_q <= enc_status;
              note_q   <= enc_note;
              vel_q    <= enc_vel;
              valid_q  <= 1'b1;
              data_q   <= rs_skip ? enc_note : enc_status;
              state    <= rs_skip ? EMIT_N : EMIT_S;
            end
          end else if (timeout) begin
            cyc    <= 1'b0;
            stb    <= 1'b0;
            wb_err <= 1'b1;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + 4'd1;
          end
        end
        EMIT_S: if (bus.midi_ready) begin
          data_q <= note_q;
          state  <= EMIT_N;
        end
        EMIT_N: if (bus.midi_ready) begin
          data_q <= vel_q;
          state  <= EMIT_V;
        end
        EMIT_V: if (bus.midi_ready) begin
          valid_q <= 1'b0;
          state   <= enable ? RD_STATUS : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
